// File: rtl/mem_access_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage_pkg
// Description : Types and constants for the MIPS memory-access stage. This
//               package holds the controller state encoding, the default
//               bus timeout and the mask that turns a byte address into a
//               word address.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_stage_pkg;

  // Memory-stage controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  // Maximum number of WAIT cycles without mem_ack before a bus error
  localparam int unsigned c_timeout_default = 15;

  // Clears byte-offset bits to form a word address
  localparam logic [31:0] c_word_align_mask = 32'hFFFF_FFFC;

endpackage
`default_nettype wire

// File: rtl/mem_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : mem_timeout_counter
// Description : 8-bit cycle counter used to time out memory accesses.
//               Synchronous clear has priority over enable. o_terminal is
//               high while the count equals TERMINAL.
// Ports       : clk        - clock, rising edge
//               reset      - asynchronous active-low reset
//               i_clear    - return count to zero
//               i_enable   - increment count
//               o_terminal - count == TERMINAL
// Revision    : 1.0 - initial release
// ============================================================================
module mem_timeout_counter #(
  parameter int unsigned TERMINAL = 14
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam logic [7:0] c_terminal = TERMINAL[7:0];

  logic [7:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= 8'd0;
    end else if (i_clear) begin
      r_count <= 8'd0;
    end else if (i_enable) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_terminal = (r_count == c_terminal);

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : Memory-stage controller. It converts MemRead/MemWrite into a
//               req/ack transaction on a variable-latency data memory, stalls
//               the upstream pipeline while the access is outstanding, and
//               delivers load data plus gated RegWrite to MEM/WB.
// Ports       : clk, reset (async active-low)
//               MemRead_IN, MemWrite_IN, RegWrite_IN, ALUResult_IN,
//               WriteData_IN          - from EX/MEM
//               mem_ack, mem_rdata    - memory response
//               mem_req, mem_we, mem_addr, mem_wdata - memory request
//               Stall_OUT             - hold PC, IF/ID, ID/EX, EX/MEM
//               ReadData_OUT, RegWrite_OUT, Misaligned_OUT,
//               BusError_OUT          - to MEM/WB
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = c_timeout_default
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead_IN,
  input  logic        MemWrite_IN,
  input  logic        RegWrite_IN,
  input  logic [31:0] ALUResult_IN,
  input  logic [31:0] WriteData_IN,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        Stall_OUT,
  output logic [31:0] ReadData_OUT,
  output logic        RegWrite_OUT,
  output logic        Misaligned_OUT,
  output logic        BusError_OUT
);

  mem_state_e  r_state;
  mem_state_e  w_state_next;

  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_buserr;

  logic        w_mem_op;
  logic        w_aligned;
  logic        w_start;
  logic        w_ack;
  logic        w_timeout;
  logic        w_cnt_clear;
  logic        w_cnt_en;
  logic        w_terminal;

  assign w_mem_op  = MemRead_IN | MemWrite_IN;
  assign w_aligned = (ALUResult_IN[1:0] == 2'b00);

  // Transaction events; mem_ack is only meaningful while waiting, and an ack
  // on the terminal-count edge beats the timeout.
  assign w_start   = (r_state == IDLE) && w_mem_op && w_aligned;
  assign w_ack     = (r_state == WAIT) && mem_ack;
  assign w_timeout = (r_state == WAIT) && !mem_ack && w_terminal;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    Stall_OUT    = 1'b0;
    w_cnt_clear  = 1'b1;
    w_cnt_en     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_mem_op && w_aligned) begin
          Stall_OUT    = 1'b1;
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        Stall_OUT   = 1'b1;
        w_cnt_clear = 1'b0;
        if (mem_ack || w_terminal) begin
          w_state_next = DONE;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      DONE: begin
        // Pipeline advances at the end of this cycle
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // WAIT-cycle counter; terminal at TIMEOUT-1 so exactly TIMEOUT WAIT cycles
  // elapse before the bus error.
  // --------------------------------------------------------------------------
  mem_timeout_counter #(
    .TERMINAL (TIMEOUT - 1)
  ) u_timeout_counter (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_cnt_clear),
    .i_enable   (w_cnt_en),
    .o_terminal (w_terminal)
  );

  // --------------------------------------------------------------------------
  // Request, read-data and error registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_rdata  <= 32'd0;
      r_buserr <= 1'b0;
    end else begin
      if (w_start) begin
        r_req   <= 1'b1;
        r_we    <= MemWrite_IN;
        r_addr  <= ALUResult_IN & c_word_align_mask;
        r_wdata <= WriteData_IN;
      end else if (w_ack) begin
        r_req <= 1'b0;
        // Stores leave the previous load result untouched
        if (!r_we) begin
          r_rdata <= mem_rdata;
        end
      end else if (w_timeout) begin
        r_req    <= 1'b0;
        r_rdata  <= 32'd0;
        r_buserr <= 1'b1;
      end

      if (r_state == DONE) begin
        r_buserr <= 1'b0;
      end
    end
  end

  assign mem_req        = r_req;
  assign mem_we         = r_we;
  assign mem_addr       = r_addr;
  assign mem_wdata      = r_wdata;
  assign ReadData_OUT   = r_rdata;
  assign BusError_OUT   = r_buserr;
  assign Misaligned_OUT = w_mem_op && !w_aligned;
  assign RegWrite_OUT   = RegWrite_IN && !Misaligned_OUT && !BusError_OUT;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Self-checking bench for mem_access_stage: a table of
//               directed operations, a reset-during-WAIT sequence and a
//               batch of random operations predicted by a transaction-level
//               model of the stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

  localparam int T = 15;

  logic        clk;
  logic        reset;
  logic        MemRead_IN;
  logic        MemWrite_IN;
  logic        RegWrite_IN;
  logic [31:0] ALUResult_IN;
  logic [31:0] WriteData_IN;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        Stall_OUT;
  logic [31:0] ReadData_OUT;
  logic        RegWrite_OUT;
  logic        Misaligned_OUT;
  logic        BusError_OUT;

  mem_access_stage #(.TIMEOUT(T)) dut (
    .clk            (clk),
    .reset          (reset),
    .MemRead_IN     (MemRead_IN),
    .MemWrite_IN    (MemWrite_IN),
    .RegWrite_IN    (RegWrite_IN),
    .ALUResult_IN   (ALUResult_IN),
    .WriteData_IN   (WriteData_IN),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .Stall_OUT      (Stall_OUT),
    .ReadData_OUT   (ReadData_OUT),
    .RegWrite_OUT   (RegWrite_OUT),
    .Misaligned_OUT (Misaligned_OUT),
    .BusError_OUT   (BusError_OUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rdata;

  // lat: WAIT cycle (1-based) in which mem_ack is given; outside 1..T = never
  typedef struct {
    logic        rd;
    logic        wr;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    int          exp_stall;
    logic        exp_mis;
    logic        exp_rw;
    logic        exp_be;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level prediction of one operation's outcome
  function automatic vec_t predict(input vec_t v, input logic [31:0] prev);
    vec_t r;
    r           = v;
    r.exp_stall = 0;
    r.exp_mis   = 1'b0;
    r.exp_be    = 1'b0;
    r.exp_rw    = v.rw;
    r.exp_rd    = prev;
    if (v.rd || v.wr) begin
      if (v.addr % 4 != 0) begin
        r.exp_mis = 1'b1;
        r.exp_rw  = 1'b0;
      end else if (v.lat >= 1 && v.lat <= T) begin
        r.exp_stall = 1 + v.lat;
        if (v.rd) r.exp_rd = v.rdata;
      end else begin
        r.exp_stall = 1 + T;
        r.exp_be    = 1'b1;
        r.exp_rw    = 1'b0;
        r.exp_rd    = 32'd0;
      end
    end
    return r;
  endfunction

  // Called just after a rising edge; returns just after the rising edge that
  // ends the operation's completion cycle.
  task automatic do_op(input vec_t v, input bit stray);
    int stall_n;
    int req_n;
    bit done;
    stall_n = 0;
    req_n   = 0;
    done    = 0;
    MemRead_IN   = v.rd;
    MemWrite_IN  = v.wr;
    RegWrite_IN  = v.rw;
    ALUResult_IN = v.addr;
    WriteData_IN = v.wdata;
    mem_ack      = 1'b0;
    for (int c = 0; c < T + 8 && !done; c++) begin
      @(negedge clk);
      if (Stall_OUT) begin
        stall_n++;
        if (mem_req) begin
          req_n++;
          chk("wait_addr", mem_addr, {v.addr[31:2], 2'b00});
          chk("wait_we", {31'd0, mem_we}, {31'd0, v.wr});
          if (v.wr) chk("wait_wdata", mem_wdata, v.wdata);
          mem_ack = (v.lat == req_n);
        end else begin
          mem_ack = stray ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        mem_rdata = mem_ack ? v.rdata : $urandom;
      end else begin
        done = 1;
        chk("stall_cycles", stall_n, v.exp_stall);
        chk("req_cycles", req_n, (v.exp_stall == 0) ? 0 : v.exp_stall - 1);
        chk("done_req", {31'd0, mem_req}, 32'd0);
        chk("misaligned", {31'd0, Misaligned_OUT}, {31'd0, v.exp_mis});
        chk("regwrite", {31'd0, RegWrite_OUT}, {31'd0, v.exp_rw});
        chk("buserror", {31'd0, BusError_OUT}, {31'd0, v.exp_be});
        chk("readdata", ReadData_OUT, v.exp_rd);
        mem_ack   = stray ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata = $urandom;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL op_complete: got no completion expected stall %0d", v.exp_stall);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //          rd    wr    rw    addr          wdata         rdata         lat stl mis   rw    be    rd_exp
    tbl[0] = '{1'b1, 1'b0, 1'b1, 32'h00000010, 32'h0,        32'hDEADBEEF, 1,  2,  1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 32'h00000020, 32'h12345678, 32'h0BADF00D, 4,  5,  1'b0, 1'b0, 1'b0, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 32'h00000013, 32'h0,        32'h11111111, 1,  0,  1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 32'h00000040, 32'h0,        32'h22222222, 0,  16, 1'b0, 1'b0, 1'b1, 32'h00000000};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 32'h00000044, 32'h0,        32'hCAFEF00D, 15, 16, 1'b0, 1'b1, 1'b0, 32'hCAFEF00D};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 32'h00000003, 32'h0,        32'h33333333, 1,  0,  1'b0, 1'b1, 1'b0, 32'hCAFEF00D};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 32'h00000022, 32'h44444444, 32'h0,        1,  0,  1'b1, 1'b0, 1'b0, 32'hCAFEF00D};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 32'h00000080, 32'h0,        32'h55AA55AA, 14, 15, 1'b0, 1'b0, 1'b0, 32'h55AA55AA};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 32'h00000084, 32'hA5A5A5A5, 32'h66666666, 1,  2,  1'b0, 1'b1, 1'b0, 32'h55AA55AA};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 32'h00000100, 32'h0,        32'h0,        1,  0,  1'b0, 1'b0, 1'b0, 32'h55AA55AA};

    // Reset state
    reset        = 1'b0;
    MemRead_IN   = 1'b0;
    MemWrite_IN  = 1'b0;
    RegWrite_IN  = 1'b0;
    ALUResult_IN = 32'd0;
    WriteData_IN = 32'd0;
    mem_ack      = 1'b0;
    mem_rdata    = 32'd0;
    #12;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", ReadData_OUT, 32'd0);
    chk("rst_buserr", {31'd0, BusError_OUT}, 32'd0);
    chk("rst_stall", {31'd0, Stall_OUT}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Directed table, back to back
    for (int i = 0; i < 10; i++) do_op(tbl[i], 1'b0);
    exp_rdata = tbl[9].exp_rd;

    // Reset pulsed low in the middle of WAIT
    MemRead_IN   = 1'b1;
    MemWrite_IN  = 1'b0;
    RegWrite_IN  = 1'b1;
    ALUResult_IN = 32'h00000100;
    mem_ack      = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("midrst_req_before", {31'd0, mem_req}, 32'd1);
    #2;
    reset      = 1'b0;
    MemRead_IN = 1'b0;
    #1;
    chk("midrst_req_async", {31'd0, mem_req}, 32'd0);
    chk("midrst_stall", {31'd0, Stall_OUT}, 32'd0);
    chk("midrst_rdata", ReadData_OUT, 32'd0);
    @(negedge clk);
    #2;
    reset     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hBADBAD00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_ack_req", {31'd0, mem_req}, 32'd0);
      chk("late_ack_stall", {31'd0, Stall_OUT}, 32'd0);
      chk("late_ack_rdata", ReadData_OUT, 32'd0);
    end
    mem_ack   = 1'b0;
    exp_rdata = 32'd0;
    @(posedge clk);
    #1;

    // Random operations against the model
    for (int i = 0; i < 60; i++) begin
      int k;
      k       = $urandom_range(0, 2);
      v.rd    = (k == 1);
      v.wr    = (k == 2);
      v.rw    = 1'($urandom_range(0, 1));
      v.addr  = $urandom;
      if ($urandom_range(0, 3) != 0) v.addr[1:0] = 2'b00;
      v.wdata = $urandom;
      v.rdata = $urandom;
      v.lat   = $urandom_range(1, T + 1);
      v       = predict(v, exp_rdata);
      do_op(v, 1'b1);
      exp_rdata = v.exp_rd;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-stage controller for the pipelined MIPS core, between the EX/MEM pipeline register and the MEM/WB register. It turns the MemRead/MemWrite controls into a request/acknowledge transaction on a variable-latency data memory and stalls the upstream pipeline until the access completes. It hands ReadData, plus control gated for misalignment and bus errors, to MEM/WB, which samples on the falling clock edge.

## Interface
- TIMEOUT, 15: maximum WAIT cycles without mem_ack before a bus error (1..255).
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemRead_IN  in  1  load requested (from EX/MEM).
- MemWrite_IN  in  1  store requested; MemRead_IN and MemWrite_IN are never both 1.
- RegWrite_IN  in  1  write-back enable of the current instruction.
- ALUResult_IN  in  32  byte address.
- WriteData_IN  in  32  store data.
- mem_ack  in  1  memory completion; sampled only in WAIT.
- mem_rdata  in  32  load data; valid when mem_ack=1.
- mem_req  out  1  registered request.
- mem_we  out  1  registered write enable.
- mem_addr  out  32  registered word address: {ALUResult_IN[31:2],2'b00}.
- mem_wdata  out  32  registered store data.
- Stall_OUT  out  1  combinational; holds PC, IF/ID, ID/EX and EX/MEM.
- ReadData_OUT  out  32  registered load result to MEM/WB.
- RegWrite_OUT  out  1  RegWrite_IN gated by the error flags; goes to MEM/WB.
- Misaligned_OUT  out  1  combinational; memory op with ALUResult_IN[1:0]!=0.
- BusError_OUT  out  1  registered; asserted in DONE after a timeout.

## Operation
- States: IDLE, WAIT, DONE.
- Reset: state=IDLE; mem_req, mem_we, mem_addr, mem_wdata, ReadData_OUT and BusError_OUT all 0; timeout counter 0.
- Definitions:
  - mem_op = MemRead_IN | MemWrite_IN.
  - aligned = (ALUResult_IN[1:0]==0).
- IDLE, mem_op & aligned:
  - Stall_OUT=1.
  - At the clock edge, latch addr/wdata/we and set mem_req=1; go to WAIT; counter=0.
- IDLE, mem_op & ~aligned:
  - No request and no stall; Misaligned_OUT=1; RegWrite_OUT=0.
- IDLE, no mem_op: pass-through; no stall; ReadData_OUT holds its value.
- WAIT:
  - Stall_OUT=1; mem_req, mem_addr, mem_we and mem_wdata stay stable.
  - If mem_ack: capture ReadData_OUT=mem_rdata on a load (unchanged on a store); mem_req=0; go to DONE.
  - Else if counter==TIMEOUT-1: set mem_req=0, ReadData_OUT=0, BusError_OUT=1; go to DONE.
  - Else increment the counter.
- DONE:
  - Stall_OUT=0; the pipeline advances at the end of this cycle; go to IDLE.
  - Clear BusError_OUT when leaving DONE.
- RegWrite_OUT = RegWrite_IN & ~Misaligned_OUT & ~BusError_OUT.
- Simultaneous mem_ack and timeout on the same edge: the ack wins and there is no error.
- mem_ack outside WAIT is ignored.
- Reset asserted mid-WAIT drops mem_req immediately; any memory response after that is ignored.

## Timing
- Aligned access with mem_ack in the first WAIT cycle: Stall_OUT high for 2 cycles (IDLE, WAIT); data is in ReadData_OUT during DONE.
- Each extra cycle of ack latency adds one stall cycle.
- Timeout: Stall_OUT high for 1+TIMEOUT cycles, then one DONE cycle.
- ReadData_OUT and RegWrite_OUT are stable from the DONE rising edge, ahead of the MEM/WB falling-edge capture.
- Back-to-back memory ops: IDLE → WAIT → DONE → IDLE; the next op starts one cycle after DONE (minimum 3 cycles per op).
- Misaligned and non-memory ops complete in 1 cycle with no stall.

## Structure
- Shared package:
  - state enum (IDLE=2'd0, WAIT=2'd1, DONE=2'd2);
  - TIMEOUT default;
  - word-alignment mask constant.
- Sub-module mem_timeout_counter: 8-bit counter with clear, enable and terminal-count output; async active-low reset.
- Top level: FSM, request registers, ReadData register and gating logic.

## Test plan
- Load from 0x00000010, mem_ack one cycle after mem_req with mem_rdata=0xDEADBEEF:
  - Stall_OUT high for 2 cycles, mem_addr=0x10, mem_we=0;
  - ReadData_OUT=0xDEADBEEF in DONE; RegWrite_OUT=1.
- Store of 0x12345678 to 0x20, mem_ack after 4 WAIT cycles:
  - mem_we=1 and mem_wdata=0x12345678 stable throughout WAIT;
  - Stall_OUT high for 5 cycles; ReadData_OUT unchanged.
- Load from 0x00000013:
  - Misaligned_OUT=1, RegWrite_OUT=0, mem_req stays 0, no stall.
- Load with mem_ack never asserted, TIMEOUT=15:
  - mem_req drops after 15 WAIT cycles;
  - BusError_OUT=1, ReadData_OUT=0, RegWrite_OUT=0 in DONE; then back to IDLE.
- mem_ack on the same edge the counter reaches 14:
  - no bus error, data captured.
- Reset pulsed low during WAIT:
  - mem_req drops immediately (asynchronously), state returns to IDLE;
  - a later mem_ack is ignored.
